scale_rom_arbiter: RTL and testbench

Shares one synchronous scale ROM (4-bit address, 8-bit data, one-cycle read latency) between two requesters, e.g. the two note-generation channels of the music player. Each cycle it grants at most one pending lookup, drives the ROM address and tracks the in-flight read with a tag pipeline. When the ROM data returns, it registers the data and pulses the owning requester's valid. Lookups are fully pipelined: one grant per cycle, back-to-back.

---
 rtl/scale_rom_arbiter.sv | 115 +++++++++++
 tb/tb_scale_rom_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/scale_rom_arbiter.sv
// Shares one synchronous scale ROM between two requesters, one lookup granted per cycle.
// Define SCALE_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module scale_rom_arbiter #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int ROM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack0,
    output logic              ack1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic [DATA_W-1:0] dout,
    output logic              valid0,
    output logic              valid1
);

    logic                   w_gnt0;
    logic                   w_gnt1;
    logic [ROM_LATENCY-1:0] w_vld_in;
    logic [ROM_LATENCY-1:0] w_id_in;
    logic [ROM_LATENCY-1:0] r_tag_vld;
    logic [ROM_LATENCY-1:0] r_tag_id;
    logic [DATA_W-1:0]      r_dout;
    logic                   r_valid0;
    logic                   r_valid1;

`ifdef SCALE_ARB_RR_EN
    logic r_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (w_gnt0) begin
            r_last <= 1'b0;
        end else if (w_gnt1) begin
            r_last <= 1'b1;
        end
    end
`endif

    // Grants are suppressed while reset is high so nothing reaches the ROM or tag pipe.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
`ifdef SCALE_ARB_RR_EN
            if (req0 && req1) begin
                w_gnt0 = r_last;
                w_gnt1 = !r_last;
            end else begin
                w_gnt0 = req0;
                w_gnt1 = req1;
            end
`else
            w_gnt0 = req0;
            w_gnt1 = req1 && !req0;
`endif
        end
    end

    always_comb begin
        rom_addr = '0;
        if (w_gnt0) begin
            rom_addr = addr0;
        end else if (w_gnt1) begin
            rom_addr = addr1;
        end
    end

    assign ack0 = w_gnt0;
    assign ack1 = w_gnt1;

    // Tag stage 0 takes the current grant; later stages follow the ROM's internal delay.
    genvar gi;
    generate
        for (gi = 0; gi < ROM_LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_vld_in[gi] = w_gnt0 || w_gnt1;
                assign w_id_in[gi]  = w_gnt1;
            end else begin : g_body
                assign w_vld_in[gi] = r_tag_vld[gi-1];
                assign w_id_in[gi]  = r_tag_id[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
            r_dout    <= '0;
            r_valid0  <= 1'b0;
            r_valid1  <= 1'b0;
        end else begin
            r_tag_vld <= w_vld_in;
            r_tag_id  <= w_id_in;
            r_valid0  <= r_tag_vld[ROM_LATENCY-1] && !r_tag_id[ROM_LATENCY-1];
            r_valid1  <= r_tag_vld[ROM_LATENCY-1] && r_tag_id[ROM_LATENCY-1];
            if (r_tag_vld[ROM_LATENCY-1]) begin
                r_dout <= rom_dout;
            end
        end
    end

    assign dout   = r_dout;
    assign valid0 = r_valid0;
    assign valid1 = r_valid1;

endmodule

// File: tb/tb_scale_rom_arbiter.sv
// Directed bench for scale_rom_arbiter with a one-cycle synchronous ROM model.
// Contention expectations follow SCALE_ARB_RR_EN when it is defined for the build.
module tb_scale_rom_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [3:0] addr0, addr1, rom_addr;
    logic [7:0] rom_dout, dout;
    logic       ack0, ack1, valid0, valid1;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         h1_id, h2_id;
    logic [3:0] h1_a, h2_a;
    logic [7:0] exp_dout;

    always #5 clk = ~clk;

    // ROM contents: 8'h5A xor {a, ~a}, e.g. ROM[3] = 8'h66, ROM[5] = 8'h00.
    function automatic logic [7:0] rom_val(input logic [3:0] a);
        return 8'h5A ^ {a, ~a};
    endfunction

    always @(posedge clk) rom_dout <= rom_val(rom_addr);

    scale_rom_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .addr0    (addr0),
        .req1     (req1),
        .addr1    (addr1),
        .ack0     (ack0),
        .ack1     (ack1),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout),
        .dout     (dout),
        .valid0   (valid0),
        .valid1   (valid1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check grant outputs for eg (0 none, 1 req0, 2 req1)
    // and the registered result of the grant made two cycles earlier.
    task automatic cyc(input logic rst, input logic r0, input logic [3:0] a0,
                       input logic r1, input logic [3:0] a1,
                       input int eg, input logic [3:0] ea);
        reset = rst;
        req0  = r0;
        addr0 = a0;
        req1  = r1;
        addr1 = a1;
        #1;
        check("ack0", ack0, eg == 1);
        check("ack1", ack1, eg == 2);
        check("rom_addr", rom_addr, (eg != 0) ? ea : 4'd0);
        check("valid0", valid0, h2_id == 1);
        check("valid1", valid1, h2_id == 2);
        if (h2_id != 0) exp_dout = rom_val(h2_a);
        check("dout", dout, exp_dout);
        $display("t=%0t rst=%0b req=%0b%0b ack=%0b%0b rom_addr=%0h valid=%0b%0b dout=%02h",
                 $time, rst, r0, r1, ack0, ack1, rom_addr, valid0, valid1, dout);
        h2_id = h1_id;
        h2_a  = h1_a;
        h1_id = eg;
        h1_a  = ea;
        if (rst) begin
            h1_id    = 0;
            h2_id    = 0;
            exp_dout = 8'h00;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        addr0 = 4'd0;
        addr1 = 4'd0;
        h1_id = 0;
        h2_id = 0;
        h1_a  = 4'd0;
        h2_a  = 4'd0;
        exp_dout = 8'h00;
        @(negedge clk);
        @(negedge clk);

        // Reset state with both requests high: grants forced off, outputs at reset values.
        cyc(1, 1, 4'd7, 1, 4'd9, 0, 4'd0);

        // Single lookup from requester 0 to address 3.
        cyc(0, 1, 4'd3, 0, 4'd0, 1, 4'd3);
        for (int k = 0; k < 3; k++) cyc(0, 0, 4'd0, 0, 4'd0, 0, 4'd0);

        // Continuous contention right after reset.
        cyc(1, 0, 4'd0, 0, 4'd0, 0, 4'd0);
        for (int k = 0; k < 6; k++) begin
`ifdef SCALE_ARB_RR_EN
            if (k % 2 == 0) cyc(0, 1, 4'd2, 1, 4'd9, 1, 4'd2);
            else            cyc(0, 1, 4'd2, 1, 4'd9, 2, 4'd9);
`else
            cyc(0, 1, 4'd2, 1, 4'd9, 1, 4'd2);
`endif
        end
        for (int k = 0; k < 2; k++) cyc(0, 0, 4'd0, 0, 4'd0, 0, 4'd0);

        // Requester 1 streams addresses 0..15 back to back.
        for (int k = 0; k < 16; k++) cyc(0, 0, 4'd0, 1, 4'(k), 2, 4'(k));

        // Drain, then ten idle cycles with dout holding ROM[15].
        for (int k = 0; k < 12; k++) cyc(0, 0, 4'd0, 0, 4'd0, 0, 4'd0);

        // Grant to address 5, then reset the next cycle: the lookup must vanish.
        cyc(0, 1, 4'd5, 0, 4'd0, 1, 4'd5);
        cyc(1, 1, 4'd5, 1, 4'd4, 0, 4'd0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 4'd0, 0, 4'd0, 0, 4'd0);

        // First cycle after reset can grant; requester 1 alone to address 12.
        cyc(0, 0, 4'd0, 1, 4'd12, 2, 4'd12);
        for (int k = 0; k < 3; k++) cyc(0, 0, 4'd0, 0, 4'd0, 0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
